vga_timing_ctrl: RTL and testbench
==================================

# vga_timing_ctrl

- Generates the 640x480@60 Hz raster timing consumed by the game display logic: `hCount`, `vCount` and `bright` go out to the display logic; 12-bit `rgb` comes back.
- Drives the VGA pins with sync and blanked colour, registered and aligned with each other.
- Emits a per-frame strobe and a slow `game_tick` strobe so game state updates at a visible rate without a second clock domain.

## Interface
- `CLK_DIV`, 4: system clocks per pixel (100 MHz in, 25 MHz pixel rate).
- `H_TOTAL`, 800: pixels per line; `H_SYNC`, 96: hSync low width; `H_VIS_START`, 144; `H_VIS_END`, 783 (inclusive).
- `V_TOTAL`, 525: lines per frame; `V_SYNC`, 2: vSync low width; `V_VIS_START`, 35; `V_VIS_END`, 514 (inclusive).
- `FRAMES_PER_TICK`, 15: frames per `game_tick`; legal range 1..255.
- `clk` in 1: system clock. One clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rgb` in 12: pixel colour from the display logic ({R,G,B} 4 bits each), valid for the current `hCount`/`vCount`.
- `hCount` out 10: pixel column, 0..H_TOTAL-1.
- `vCount` out 10: line number, 0..V_TOTAL-1.
- `bright` out 1: high when `hCount` is in [H_VIS_START, H_VIS_END] and `vCount` is in [V_VIS_START, V_VIS_END].
- `pix_en` out 1: one-`clk` pixel-rate strobe.
- `frame_start` out 1: one-`clk` pulse when counters wrap to (0,0).
- `game_tick` out 1: one-`clk` pulse on every FRAMES_PER_TICK-th `frame_start`.
- `hSync` out 1: registered horizontal sync to the pin, active low.
- `vSync` out 1: registered vertical sync to the pin, active low.
- `vgaR` out 4, `vgaG` out 4, `vgaB` out 4: registered colour to the pins, forced to 0 outside the visible area.

## Operation
- **Divider.** `div_cnt` counts 0..CLK_DIV-1 and wraps. `pix_en` is the decode `div_cnt == CLK_DIV-1`.
- **Horizontal counter.** On `clk` with `pix_en`, `hCount` increments. At H_TOTAL-1 it wraps to 0 and `vCount` increments.
- **Vertical counter.** `vCount` wraps to 0 from V_TOTAL-1 when `hCount` wraps. No other counter states exist.
- **Stage 0 (counter stage).** `hCount`, `vCount` and `bright` are decoded from the counter registers and are driven to the display logic.
- **Stage 1 (pin stage), on `pix_en`:**
  - `hSync` <= !(hCount < H_SYNC)
  - `vSync` <= !(vCount < V_SYNC)
  - `{vgaR,vgaG,vgaB}` <= bright ? rgb : 0
- **Frame counter.** `frame_cnt` (8 bits) increments on each wrap to (0,0). On a wrap with `frame_cnt == FRAMES_PER_TICK-1`, it clears to 0 and `game_tick` fires.
- **Reset values.** While `rst_n` is low, all registers clear:
  - `div_cnt` = 0, `hCount` = 0, `vCount` = 0, `frame_cnt` = 0
  - `hSync` = 1, `vSync` = 1, `vgaR/G/B` = 0
  - `frame_start` = 0, `game_tick` = 0, `pix_en` = 0, `bright` = 0
- **Reset mid-frame.** Counters restart at (0,0). Reset itself produces no `frame_start`. The tick count restarts from 0.

## Timing
- **First strobe.** The first `pix_en` is high in the 4th `clk` cycle after `rst_n` rises (CLK_DIV-th cycle). It then repeats every CLK_DIV cycles.
- **Counter update.** `hCount` changes on the `clk` edge that ends a `pix_en` cycle.
- **Colour path.** `rgb` is sampled on that same edge, so the display logic has one full pixel period (CLK_DIV clks) of combinational budget.
- **Pin alignment.** Pins lag `hCount`/`vCount` by exactly one pixel period. `hSync`, `vSync` and colour are mutually aligned.
- **`frame_start`.** Registered. High for the one `clk` immediately after the edge on which counters move from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- **`game_tick`.** Coincides with the qualifying `frame_start`.
- **Periods at defaults.**
  - Line = 3200 clks; frame = 1 680 000 clks.
  - hSync low for 384 clks per line; vSync low for 6400 clks per frame.
  - `game_tick` period = 25 200 000 clks.
- **FRAMES_PER_TICK = 1.** `game_tick` is identical to `frame_start`.

## Structure
- **Package `vga_pkg`:**
  - default timing localparams (800/96/144/783, 525/2/35/514)
  - 12-bit colour type
  - colour constants WHITE 12'hFFF, GRAY 12'h888, ORANGE 12'hF80, RED 12'hF00, GREEN 12'h0F0
- **Sub-module `pix_en_div`:** CLK_DIV counter producing `pix_en`, with async active-low clear.
- **Top level:** counters, decode, pin pipeline stage and frame counter.

## Test plan
- **Strobe after reset.** Release `rst_n` at t0 → `pix_en` high in cycles 4, 8, 12… and `hCount` reads 1 after cycle 4. All outputs hold their reset values before that.
- **Line and frame periods.** Default params, run 2 lines → `hSync` low for 384 clks starting 4 clks after `hCount` = 0, period 3200 clks. `vSync` low for 6400 clks per 1 680 000-clk frame.
- **Blanking.** Drive `rgb` = 12'hF80 constant.
  - `vgaR/G/B` = F/8/0 one pixel after `hCount` = 144, `vCount` = 35.
  - Zero one pixel after `hCount` = 784, and on line 515.
  - `bright` low at (143,35) and high at (144,35).
- **Tick cadence.** Reduced params (H_TOTAL 10, V_TOTAL 4, CLK_DIV 2, FRAMES_PER_TICK 3) → `frame_start` every 80 clks, `game_tick` on every 3rd `frame_start` only. With FRAMES_PER_TICK = 1, every `frame_start`.
- **Reset mid-operation.** Assert `rst_n` low at `hCount` = 500, `vCount` = 200 for 3 clks → immediate return to reset values, no `frame_start`, next `game_tick` only after FRAMES_PER_TICK full frames.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour type and palette for the raster generator and display logic.
// Latency: none (types, constants and a pure function only).
// Backpressure: none; every consumer is free-running.
package vga_pkg;

    localparam int H_TOTAL_DEF     = 800;
    localparam int H_SYNC_DEF      = 96;
    localparam int H_VIS_START_DEF = 144;
    localparam int H_VIS_END_DEF   = 783;
    localparam int V_TOTAL_DEF     = 525;
    localparam int V_SYNC_DEF      = 2;
    localparam int V_VIS_START_DEF = 35;
    localparam int V_VIS_END_DEF   = 514;

    typedef logic [11:0] color_t;

    localparam color_t WHITE  = 12'hFFF;
    localparam color_t GRAY   = 12'h888;
    localparam color_t ORANGE = 12'hF80;
    localparam color_t RED    = 12'hF00;
    localparam color_t GREEN  = 12'h0F0;

    function automatic logic in_range(input logic [9:0] val,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/pix_en_div.sv
// Divides the system clock down to a one-clk pixel-rate strobe.
// Latency: first strobe in the CLK_DIV-th clk after reset release.
// Backpressure: none; free-running.
module pix_en_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] DIV_LAST = W'(CLK_DIV - 1);

    logic [W-1:0] r_div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign pix_en = (r_div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// 640x480 raster counters, visible-area decode, registered sync/colour pins and frame/game tick strobes.
// Latency: pins lag hCount/vCount by one pixel period; frame_start/game_tick one clk after the wrap edge.
// Backpressure: none; free-running, rgb is sampled unconditionally on each pixel edge.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int CLK_DIV         = 4,
    parameter int H_TOTAL         = H_TOTAL_DEF,
    parameter int H_SYNC          = H_SYNC_DEF,
    parameter int H_VIS_START     = H_VIS_START_DEF,
    parameter int H_VIS_END       = H_VIS_END_DEF,
    parameter int V_TOTAL         = V_TOTAL_DEF,
    parameter int V_SYNC          = V_SYNC_DEF,
    parameter int V_VIS_START     = V_VIS_START_DEF,
    parameter int V_VIS_END       = V_VIS_END_DEF,
    parameter int FRAMES_PER_TICK = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] rgb,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        bright,
    output logic        pix_en,
    output logic        frame_start,
    output logic        game_tick,
    output logic        hSync,
    output logic        vSync,
    output logic [3:0]  vgaR,
    output logic [3:0]  vgaG,
    output logic [3:0]  vgaB
);

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYN_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYN_W = 10'(V_SYNC);
    localparam logic [9:0] H_VS    = 10'(H_VIS_START);
    localparam logic [9:0] H_VE    = 10'(H_VIS_END);
    localparam logic [9:0] V_VS    = 10'(V_VIS_START);
    localparam logic [9:0] V_VE    = 10'(V_VIS_END);
    localparam logic [7:0] FPT_LAST = 8'(FRAMES_PER_TICK - 1);

    logic       w_pix_en;
    logic       w_h_last;
    logic       w_wrap;
    logic       w_bright;
    logic [9:0] r_h;
    logic [9:0] r_v;
    logic [7:0] r_frame_cnt;
    logic       r_frame_start;
    logic       r_game_tick;
    logic       r_hsync;
    logic       r_vsync;
    color_t     r_col;

    pix_en_div #(.CLK_DIV(CLK_DIV)) u_pix_en_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_en (w_pix_en)
    );

    assign w_h_last = (r_h == H_LAST);
    assign w_wrap   = w_pix_en && w_h_last && (r_v == V_LAST);
    assign w_bright = in_range(r_h, H_VS, H_VE) && in_range(r_v, V_VS, V_VE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_pix_en) begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
            end else begin
                r_h <= r_h + 10'd1;
            end
        end
    end

    // Pin stage: captures the pixel currently on the counters, so pins trail by one pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_col   <= '0;
        end else if (w_pix_en) begin
            r_hsync <= !(r_h < H_SYN_W);
            r_vsync <= !(r_v < V_SYN_W);
            r_col   <= w_bright ? rgb : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt   <= '0;
            r_frame_start <= 1'b0;
            r_game_tick   <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            r_game_tick   <= w_wrap && (r_frame_cnt == FPT_LAST);
            if (w_wrap) begin
                r_frame_cnt <= (r_frame_cnt == FPT_LAST) ? 8'd0 : r_frame_cnt + 8'd1;
            end
        end
    end

    assign hCount      = r_h;
    assign vCount      = r_v;
    assign bright      = w_bright;
    assign pix_en      = w_pix_en;
    assign frame_start = r_frame_start;
    assign game_tick   = r_game_tick;
    assign hSync       = r_hsync;
    assign vSync       = r_vsync;
    assign vgaR        = r_col[11:8];
    assign vgaG        = r_col[7:4];
    assign vgaB        = r_col[3:0];

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: four parameterisations checked against a closed-form raster model.
// Latency/backpressure: not applicable (bench).
module tb_vga_timing_ctrl;

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        bright;
        logic        pix;
        logic        fs;
        logic        gt;
        logic        hs;
        logic        vs;
        logic [11:0] col;
    } obs_t;

    typedef struct {
        int         k;
        logic       pix;
        logic [9:0] h;
        logic       hs;
    } vec_t;

    // Instance D geometry (small frame so blanking and vSync fit the run).
    localparam int DD = 2, DH = 40, DHS = 4, DHVS = 8, DHVE = 35;
    localparam int DV = 12, DVS = 2, DVVS = 3, DVVE = 9, DFPT = 2;

    logic        clk;
    logic        rst_n;
    logic [11:0] rgb;

    logic [9:0] a_h, a_v, b_h, b_v, c_h, c_v, d_h, d_v;
    logic a_br, a_pix, a_fs, a_gt, a_hs, a_vs;
    logic b_br, b_pix, b_fs, b_gt, b_hs, b_vs;
    logic c_br, c_pix, c_fs, c_gt, c_hs, c_vs;
    logic d_br, d_pix, d_fs, d_gt, d_hs, d_vs;
    logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b, d_r, d_g, d_b;

    vga_timing_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .rgb(rgb), .hCount(a_h), .vCount(a_v), .bright(a_br),
        .pix_en(a_pix), .frame_start(a_fs), .game_tick(a_gt), .hSync(a_hs), .vSync(a_vs),
        .vgaR(a_r), .vgaG(a_g), .vgaB(a_b));

    vga_timing_ctrl #(.CLK_DIV(2), .H_TOTAL(10), .H_SYNC(2), .H_VIS_START(3), .H_VIS_END(8),
                      .V_TOTAL(4), .V_SYNC(1), .V_VIS_START(1), .V_VIS_END(2),
                      .FRAMES_PER_TICK(3)) u_b (
        .clk(clk), .rst_n(rst_n), .rgb(rgb), .hCount(b_h), .vCount(b_v), .bright(b_br),
        .pix_en(b_pix), .frame_start(b_fs), .game_tick(b_gt), .hSync(b_hs), .vSync(b_vs),
        .vgaR(b_r), .vgaG(b_g), .vgaB(b_b));

    vga_timing_ctrl #(.CLK_DIV(2), .H_TOTAL(10), .H_SYNC(2), .H_VIS_START(3), .H_VIS_END(8),
                      .V_TOTAL(4), .V_SYNC(1), .V_VIS_START(1), .V_VIS_END(2),
                      .FRAMES_PER_TICK(1)) u_c (
        .clk(clk), .rst_n(rst_n), .rgb(rgb), .hCount(c_h), .vCount(c_v), .bright(c_br),
        .pix_en(c_pix), .frame_start(c_fs), .game_tick(c_gt), .hSync(c_hs), .vSync(c_vs),
        .vgaR(c_r), .vgaG(c_g), .vgaB(c_b));

    vga_timing_ctrl #(.CLK_DIV(DD), .H_TOTAL(DH), .H_SYNC(DHS), .H_VIS_START(DHVS),
                      .H_VIS_END(DHVE), .V_TOTAL(DV), .V_SYNC(DVS), .V_VIS_START(DVVS),
                      .V_VIS_END(DVVE), .FRAMES_PER_TICK(DFPT)) u_d (
        .clk(clk), .rst_n(rst_n), .rgb(rgb), .hCount(d_h), .vCount(d_v), .bright(d_br),
        .pix_en(d_pix), .frame_start(d_fs), .game_tick(d_gt), .hSync(d_hs), .vSync(d_vs),
        .vgaR(d_r), .vgaG(d_g), .vgaB(d_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int k = 0;
    int seg = 0;
    bit want_rst = 1'b1;
    bit const_rgb = 1'b0;
    logic [11:0] rgb_hist [int];
    vec_t vecs [7];

    // Tracker state for the hand-measured periods.
    int a_h0, a_fall, b_prev, b_cnt, d_fall, d_on_k, d_off_k, d_offv_k, d_on_seen;
    logic [9:0] pa_h;
    logic pa_hs, pd_vs;

    // Output predicted from the number of completed pixel edges since reset release.
    function automatic obs_t model(input int kk, input bit in_rst, input int D, input int H,
                                   input int HS, input int HVS, input int HVE, input int V,
                                   input int VS, input int VVS, input int VVE, input int FPT);
        obs_t o;
        int p, q, hq, vq, hh, vv;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        if (!in_rst) begin
            p  = (kk - 1) / D;
            hh = p % H;
            vv = (p / H) % V;
            o.pix    = ((kk - 1) % D) == D - 1;
            o.h      = 10'(hh);
            o.v      = 10'(vv);
            o.bright = (hh >= HVS) && (hh <= HVE) && (vv >= VVS) && (vv <= VVE);
            if (p > 0) begin
                q  = p - 1;
                hq = q % H;
                vq = (q / H) % V;
                o.hs  = !(hq < HS);
                o.vs  = !(vq < VS);
                o.col = ((hq >= HVS) && (hq <= HVE) && (vq >= VVS) && (vq <= VVE))
                        ? rgb_hist[p * D] : 12'h000;
            end
            o.fs = (((kk - 1) % D) == 0) && (p > 0) && ((p % (H * V)) == 0);
            o.gt = o.fs && (((p / (H * V)) % FPT) == 0);
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d seg=%0d actual=%h expected=%h", name, k, seg, act, exp);
        end
    endtask

    task automatic step();
        obs_t oa, ob, oc, od;
        @(posedge clk);
        #1;
        rst_n = !want_rst;
        if (want_rst) k = 0;
        else          k++;
        rgb = const_rgb ? 12'hF80 : 12'($urandom);
        rgb_hist[k] = rgb;
        #1;
        oa = '{a_h, a_v, a_br, a_pix, a_fs, a_gt, a_hs, a_vs, {a_r, a_g, a_b}};
        ob = '{b_h, b_v, b_br, b_pix, b_fs, b_gt, b_hs, b_vs, {b_r, b_g, b_b}};
        oc = '{c_h, c_v, c_br, c_pix, c_fs, c_gt, c_hs, c_vs, {c_r, c_g, c_b}};
        od = '{d_h, d_v, d_br, d_pix, d_fs, d_gt, d_hs, d_vs, {d_r, d_g, d_b}};
        chk("model_A", 64'(oa), 64'(model(k, want_rst, 4, 800, 96, 144, 783, 525, 2, 35, 514, 15)));
        chk("model_B", 64'(ob), 64'(model(k, want_rst, 2, 10, 2, 3, 8, 4, 1, 1, 2, 3)));
        chk("model_C", 64'(oc), 64'(model(k, want_rst, 2, 10, 2, 3, 8, 4, 1, 1, 2, 1)));
        chk("model_D", 64'(od), 64'(model(k, want_rst, DD, DH, DHS, DHVS, DHVE, DV, DVS,
                                          DVVS, DVVE, DFPT)));
        if (want_rst) begin
            pa_h = '0; pa_hs = 1'b1; a_h0 = 0; a_fall = 0;
            b_prev = 0; b_cnt = 0; d_fall = 0; pd_vs = 1'b1;
            d_on_k = -1; d_off_k = -1; d_offv_k = -1;
        end else begin
            if (seg == 1) begin
                for (int i = 0; i < 7; i++) begin
                    if (vecs[i].k == k) begin
                        chk("vec_pix_en", 64'(a_pix), 64'(vecs[i].pix));
                        chk("vec_hcount", 64'(a_h), 64'(vecs[i].h));
                        chk("vec_hsync", 64'(a_hs), 64'(vecs[i].hs));
                    end
                end
            end
            if (a_h == 10'd0 && (k == 1 || pa_h != 10'd0)) a_h0 = k;
            if (pa_hs && !a_hs) begin
                chk("hsync_lead", 64'(k - a_h0), 64'd4);
                if (a_fall > 0) chk("hsync_period", 64'(k - a_fall), 64'd3200);
                a_fall = k;
            end
            if (!pa_hs && a_hs && a_fall > 0) chk("hsync_low", 64'(k - a_fall), 64'd384);
            pa_h = a_h;
            pa_hs = a_hs;

            if (b_fs) begin
                b_cnt++;
                if (b_prev > 0) chk("fs_period", 64'(k - b_prev), 64'd80);
                else            chk("first_fs", 64'(k), 64'd81);
                chk("tick_cadence", 64'(b_gt), 64'((b_cnt % 3) == 0));
                b_prev = k;
            end
            if (c_fs || c_gt) chk("tick_fpt1", 64'(c_gt), 64'(c_fs));

            if (pd_vs && !d_vs) begin
                if (d_fall > 0) chk("vsync_period", 64'(k - d_fall), 64'(DD * DH * DV));
                d_fall = k;
            end
            if (!pd_vs && d_vs && d_fall > 0) chk("vsync_low", 64'(k - d_fall), 64'(DD * DH * DVS));
            pd_vs = d_vs;

            if (k == d_on_k && const_rgb) begin
                chk("blank_on", 64'({d_r, d_g, d_b}), 64'h0F80);
                d_on_seen++;
            end
            if (k == d_off_k)  chk("blank_hend", 64'({d_r, d_g, d_b}), 64'h0);
            if (k == d_offv_k) chk("blank_vend", 64'({d_r, d_g, d_b}), 64'h0);
            if (d_pix && d_v == 10'(DVVS) && d_h == 10'(DHVS - 1)) chk("bright_pre", 64'(d_br), 64'd0);
            if (d_pix && d_v == 10'(DVVS) && d_h == 10'(DHVS))     chk("bright_on", 64'(d_br), 64'd1);
            if (d_pix && d_v == 10'(DVVS) && d_h == 10'(DHVS))     d_on_k = k + 1;
            if (d_pix && d_v == 10'(DVVS) && d_h == 10'(DHVE + 1)) d_off_k = k + 1;
            if (d_pix && d_v == 10'(DVVE + 1) && d_h == 10'(DHVS)) d_offv_k = k + 1;
        end
    endtask

    initial begin
        bit reached;
        vecs[0] = '{1, 1'b0, 10'd0, 1'b1};
        vecs[1] = '{2, 1'b0, 10'd0, 1'b1};
        vecs[2] = '{3, 1'b0, 10'd0, 1'b1};
        vecs[3] = '{4, 1'b1, 10'd0, 1'b1};
        vecs[4] = '{5, 1'b0, 10'd1, 1'b0};
        vecs[5] = '{8, 1'b1, 10'd1, 1'b0};
        vecs[6] = '{9, 1'b0, 10'd2, 1'b0};
        d_on_seen = 0;
        rst_n = 1'b0;
        rgb = '0;
        want_rst = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // Random colour; run until the default-timing instance sits mid-line.
        want_rst = 1'b0;
        seg = 1;
        reached = 1'b0;
        for (int n = 0; n < 12000 && !reached; n++) begin
            step();
            if (a_h == 10'd500 && a_v == 10'd2) reached = 1'b1;
        end
        chk("reach_mid_line", 64'(reached), 64'd1);

        want_rst = 1'b1;
        for (int i = 0; i < 3; i++) step();

        want_rst = 1'b0;
        const_rgb = 1'b1;
        seg = 2;
        for (int n = 0; n < 3000; n++) step();
        chk("ticks_after_reset", 64'(b_cnt >= 30), 64'd1);
        chk("blank_on_seen", 64'(d_on_seen > 0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
